// File: rtl/debug_hub_pkg.sv
// Shared types for the debug hub: host command opcodes, control FSM states
// and the debug register index width.
package debug_hub_pkg;

  localparam int DBG_REG_W = 4;

  typedef enum logic [2:0] {
    OP_RD_DATA   = 3'd0,
    OP_WR_DATA   = 3'd1,
    OP_RD_CODE   = 3'd2,
    OP_WR_CODE   = 3'd3,
    OP_RD_DBG    = 3'd4,
    OP_SET_RESET = 3'd5,
    OP_CONTINUE  = 3'd6,
    OP_STATUS    = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_LATENCY,
    ST_RESPOND
  } state_e;

  function automatic logic op_is_read(input cmd_op_e op);
    return op inside {OP_RD_DATA, OP_RD_CODE, OP_RD_DBG};
  endfunction

endpackage

// File: rtl/debug_hub_if.sv
// Host command/response channel of the debug hub. The host drives the
// master side, the hub sits on the slave side.
interface debug_hub_if #(
  parameter int WORD_SIZE = 18,
  parameter int ADDR_SIZE = 18
);
  import debug_hub_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  cmd_op_e              cmd_op;
  logic [2:0]           cmd_core;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [WORD_SIZE-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_data;
  logic                 rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_core, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_core, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/debug_hub_wait_tracker.sv
// Reports each core entering its wait state as a one-cycle event; cores that
// enter together are reported lowest index first, one per cycle.
module debug_hub_wait_tracker #(
  parameter int NUM_CORES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] wait_for_continue,
  output logic                 wait_event,
  output logic [2:0]           wait_event_core
);

  logic [NUM_CORES-1:0] prev_wait;
  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] candidates;
  logic [NUM_CORES-1:0] pick;
  logic [2:0]           pick_idx;

  // A pending entry is dropped as soon as its core leaves the wait state.
  always_comb begin
    candidates = (pending | (wait_for_continue & ~prev_wait)) & wait_for_continue;
    pick       = candidates & (~candidates + NUM_CORES'(1));
    pick_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick[i]) pick_idx = 3'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_wait       <= '0;
      pending         <= '0;
      wait_event      <= 1'b0;
      wait_event_core <= '0;
    end else begin
      prev_wait       <= wait_for_continue;
      pending         <= candidates & ~pick;
      wait_event      <= |candidates;
      wait_event_core <= pick_idx;
    end
  end

endmodule

// File: rtl/debug_hub.sv
// Host-side debug hub: memory, debug register, reset and continue control
// for NUM_CORES processors. Define DEBUG_HUB_WAIT_EVENT_EN for wait-entry events.
module debug_hub
  import debug_hub_pkg::*;
#(
  parameter int NUM_CORES   = 2,
  parameter int WORD_SIZE   = 18,
  parameter int ADDR_SIZE   = 18,
  parameter int MEM_LATENCY = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  debug_hub_if.slave                     host,
  output logic [NUM_CORES*ADDR_SIZE-1:0] data_address,
  output logic [NUM_CORES*ADDR_SIZE-1:0] code_address,
  output logic [NUM_CORES*WORD_SIZE-1:0] data_write,
  output logic [NUM_CORES*WORD_SIZE-1:0] code_write,
  output logic [NUM_CORES-1:0]           data_wren,
  output logic [NUM_CORES-1:0]           code_wren,
  input  logic [NUM_CORES*WORD_SIZE-1:0] data_read,
  input  logic [NUM_CORES*WORD_SIZE-1:0] code_read,
  output logic [NUM_CORES-1:0]           processor_reset,
  input  logic [NUM_CORES-1:0]           wait_for_continue,
  output logic [NUM_CORES-1:0]           wait_continue_execution,
  output logic [NUM_CORES-1:0]           debug_get_param,
  output logic [DBG_REG_W-1:0]           debug_reg_addr,
  input  logic [NUM_CORES*WORD_SIZE-1:0] debug_data_out,
  output logic                           wait_event,
  output logic [2:0]                     wait_event_core
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

  state_e               state, state_next;
  cmd_op_e              op_q;
  logic [2:0]           core_q;
  logic                 set_val_q;
  logic [1:0]           lat_cnt;
  logic                 accept;
  logic                 core_ok;
  logic [NUM_CORES-1:0] core_sel;
  logic [NUM_CORES-1:0] accept_sel;
  logic [WORD_SIZE-1:0] read_sel;
  logic [WORD_SIZE-1:0] status_word;

  assign accept     = host.cmd_valid && host.cmd_ready;
  assign core_ok    = {1'b0, core_q} < 4'(NUM_CORES);
  assign core_sel   = core_ok ? (NUM_CORES'(1) << core_q) : '0;
  assign accept_sel = ({1'b0, host.cmd_core} < 4'(NUM_CORES)) ?
                      (NUM_CORES'(1) << host.cmd_core) : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    read_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_sel[i]) begin
        case (op_q)
          OP_RD_DATA: read_sel = data_read[i*WORD_SIZE +: WORD_SIZE];
          OP_RD_CODE: read_sel = code_read[i*WORD_SIZE +: WORD_SIZE];
          OP_RD_DBG:  read_sel = debug_data_out[i*WORD_SIZE +: WORD_SIZE];
          default:    ;
        endcase
      end
    end
    status_word = '0;
    status_word[2*NUM_CORES-1:0] = {processor_reset, wait_for_continue};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (accept) state_next = ST_ACCESS;
      ST_ACCESS:  state_next = (core_ok && op_is_read(op_q)) ? ST_LATENCY : ST_RESPOND;
      ST_LATENCY: if (lat_cnt == LAT_LAST) state_next = ST_RESPOND;
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the state so a reset mid-command kills them at once.
  always_comb begin
    host.cmd_ready          = (state == ST_IDLE);
    host.rsp_valid          = (state == ST_RESPOND);
    data_wren               = '0;
    code_wren               = '0;
    wait_continue_execution = '0;
    debug_get_param         = '0;
    if (state == ST_ACCESS) begin
      if (op_q == OP_WR_DATA)  data_wren = core_sel;
      if (op_q == OP_WR_CODE)  code_wren = core_sel;
      if (op_q == OP_CONTINUE) wait_continue_execution = core_sel & wait_for_continue;
    end
    if ((state == ST_ACCESS || state == ST_LATENCY) && op_q == OP_RD_DBG)
      debug_get_param = core_sel;
  end

  // NOTE: port-b address/data registers are plain registers, so they take a reset value.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q            <= OP_RD_DATA;
      core_q          <= '0;
      set_val_q       <= 1'b0;
      lat_cnt         <= '0;
      host.rsp_data   <= '0;
      host.rsp_err    <= 1'b0;
      processor_reset <= '1;
      data_address    <= '0;
      code_address    <= '0;
      data_write      <= '0;
      code_write      <= '0;
      debug_reg_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= host.cmd_op;
            core_q    <= host.cmd_core;
            set_val_q <= host.cmd_wdata[0];
            lat_cnt   <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
              if (accept_sel[i]) begin
                if (host.cmd_op inside {OP_RD_DATA, OP_WR_DATA})
                  data_address[i*ADDR_SIZE +: ADDR_SIZE] <= host.cmd_addr;
                if (host.cmd_op inside {OP_RD_CODE, OP_WR_CODE})
                  code_address[i*ADDR_SIZE +: ADDR_SIZE] <= host.cmd_addr;
                if (host.cmd_op == OP_WR_DATA)
                  data_write[i*WORD_SIZE +: WORD_SIZE] <= host.cmd_wdata;
                if (host.cmd_op == OP_WR_CODE)
                  code_write[i*WORD_SIZE +: WORD_SIZE] <= host.cmd_wdata;
              end
            end
            if (host.cmd_op == OP_RD_DBG && |accept_sel)
              debug_reg_addr <= host.cmd_addr[DBG_REG_W-1:0];
          end
        end
        ST_ACCESS: begin
          host.rsp_err  <= !core_ok;
          host.rsp_data <= '0;
          if (core_ok) begin
            case (op_q)
              OP_SET_RESET: processor_reset <= (processor_reset & ~core_sel) |
                                               (set_val_q ? core_sel : '0);
              OP_CONTINUE:  host.rsp_err <= ~|(core_sel & wait_for_continue);
              OP_STATUS:    host.rsp_data <= status_word;
              default:      ;
            endcase
          end
        end
        ST_LATENCY: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_cnt == LAT_LAST) host.rsp_data <= read_sel;
        end
        default: ;
      endcase
    end
  end

`ifdef DEBUG_HUB_WAIT_EVENT_EN
  debug_hub_wait_tracker #(
    .NUM_CORES (NUM_CORES)
  ) u_wait_tracker (
    .clock             (clock),
    .reset             (reset),
    .wait_for_continue (wait_for_continue),
    .wait_event        (wait_event),
    .wait_event_core   (wait_event_core)
  );
`else
  assign wait_event      = 1'b0;
  assign wait_event_core = '0;
`endif

endmodule

// File: tb/tb_debug_hub.sv
// Randomized bench for debug_hub: commands are checked against a
// command-level model of memory contents, reset bitmap and response timing.
`timescale 1ns/1ps
module tb_debug_hub;
  import debug_hub_pkg::*;

  localparam int NC = 2;
  localparam int W  = 18;
  localparam int A  = 18;
  localparam int L  = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  debug_hub_if #(.WORD_SIZE(W), .ADDR_SIZE(A)) bus ();

  logic [NC*A-1:0] data_address, code_address;
  logic [NC*W-1:0] data_write, code_write, data_read, code_read, debug_data_out;
  logic [NC-1:0]   data_wren, code_wren, processor_reset, wait_for_continue;
  logic [NC-1:0]   wait_continue_execution, debug_get_param;
  logic [3:0]      debug_reg_addr;
  logic            wait_event;
  logic [2:0]      wait_event_core;

  debug_hub #(
    .NUM_CORES(NC), .WORD_SIZE(W), .ADDR_SIZE(A), .MEM_LATENCY(L)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .host                    (bus),
    .data_address            (data_address),
    .code_address            (code_address),
    .data_write              (data_write),
    .code_write              (code_write),
    .data_wren               (data_wren),
    .code_wren               (code_wren),
    .data_read               (data_read),
    .code_read               (code_read),
    .processor_reset         (processor_reset),
    .wait_for_continue       (wait_for_continue),
    .wait_continue_execution (wait_continue_execution),
    .debug_get_param         (debug_get_param),
    .debug_reg_addr          (debug_reg_addr),
    .debug_data_out          (debug_data_out),
    .wait_event              (wait_event),
    .wait_event_core         (wait_event_core)
  );

  // Port-b memories attached to the hub, with L cycles of read latency.
  logic [W-1:0]    dmem [int];
  logic [W-1:0]    cmem [int];
  logic [NC*W-1:0] d_pipe [L];
  logic [NC*W-1:0] c_pipe [L];
  assign data_read = d_pipe[L-1];
  assign code_read = c_pipe[L-1];

  initial begin
    for (int i = 0; i < L; i++) begin
      d_pipe[i] = '0;
      c_pipe[i] = '0;
    end
  end

  always @(posedge clock) begin
    logic [NC*W-1:0] d_now, c_now;
    int dk, ck;
    d_now = '0;
    c_now = '0;
    for (int c = 0; c < NC; c++) begin
      dk = (c << A) | int'(data_address[c*A +: A]);
      ck = (c << A) | int'(code_address[c*A +: A]);
      d_now[c*W +: W] = dmem.exists(dk) ? dmem[dk] : '0;
      c_now[c*W +: W] = cmem.exists(ck) ? cmem[ck] : '0;
      if (data_wren[c]) dmem[dk] = data_write[c*W +: W];
      if (code_wren[c]) cmem[ck] = code_write[c*W +: W];
    end
    d_pipe[0] <= d_now;
    c_pipe[0] <= c_now;
    for (int i = 1; i < L; i++) begin
      d_pipe[i] <= d_pipe[i-1];
      c_pipe[i] <= c_pipe[i-1];
    end
  end

  // Command-level reference model.
  logic [W-1:0]  ref_mem [int];
  logic [NC-1:0] ref_preset;

  function automatic int mkey(input bit code, input int core, input logic [A-1:0] addr);
    return (int'(code) << 24) | (core << 20) | int'(addr);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int mon_dwren [NC];
  int mon_cwren [NC];
  int mon_cont  [NC];
  int mon_gp    [NC];

  // Drives one command from posedge+1 and returns the response and its latency.
  task automatic issue(input cmd_op_e op, input logic [2:0] core, input logic [A-1:0] addr,
                       input logic [W-1:0] wd, output bit got, output int lat,
                       output logic [W-1:0] data, output logic err);
    bit acc;
    got  = 1'b0;
    lat  = 0;
    data = '0;
    err  = 1'b0;
    for (int c = 0; c < NC; c++) begin
      mon_dwren[c] = 0; mon_cwren[c] = 0; mon_cont[c] = 0; mon_gp[c] = 0;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_core  = core;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clock);
      acc = bus.cmd_ready;
      @(posedge clock);
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) begin
      check("accept_timeout", 0, 1);
      return;
    end
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clock);
      lat++;
      for (int c = 0; c < NC; c++) begin
        mon_dwren[c] += int'(data_wren[c]);
        mon_cwren[c] += int'(code_wren[c]);
        mon_cont[c]  += int'(wait_continue_execution[c]);
        mon_gp[c]    += int'(debug_get_param[c]);
      end
      if (bus.rsp_valid) begin
        got  = 1'b1;
        data = bus.rsp_data;
        err  = bus.rsp_err;
      end
    end
    if (!got) check("rsp_timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic exec(input cmd_op_e op, input int core, input logic [A-1:0] addr,
                      input logic [W-1:0] wd);
    bit ok, rd, got, wbit;
    int lat, exp_lat;
    logic [W-1:0] data, exp_data;
    logic err, exp_err;
    string nm;
    nm   = op.name();
    ok   = core < NC;
    rd   = op inside {OP_RD_DATA, OP_RD_CODE, OP_RD_DBG};
    wbit = ok ? wait_for_continue[core] : 1'b0;
    exp_lat  = (ok && rd) ? L + 2 : 2;
    exp_err  = !ok || (op == OP_CONTINUE && !wbit);
    exp_data = '0;
    if (ok) begin
      case (op)
        OP_RD_DATA: exp_data = ref_mem.exists(mkey(0, core, addr)) ? ref_mem[mkey(0, core, addr)] : '0;
        OP_RD_CODE: exp_data = ref_mem.exists(mkey(1, core, addr)) ? ref_mem[mkey(1, core, addr)] : '0;
        OP_RD_DBG:  exp_data = debug_data_out[core*W +: W];
        OP_STATUS:  exp_data = W'({ref_preset, wait_for_continue});
        default:    ;
      endcase
    end
    issue(op, 3'(core), addr, wd, got, lat, data, err);
    if (got) begin
      check({nm, ".lat"}, lat, exp_lat);
      check({nm, ".err"}, err, exp_err);
      if (!ok || rd || op == OP_STATUS) check({nm, ".data"}, data, exp_data);
    end
    for (int c = 0; c < NC; c++) begin
      check({nm, ".dwren"}, mon_dwren[c], (ok && op == OP_WR_DATA && c == core) ? 1 : 0);
      check({nm, ".cwren"}, mon_cwren[c], (ok && op == OP_WR_CODE && c == core) ? 1 : 0);
      check({nm, ".cont"},  mon_cont[c],  (ok && op == OP_CONTINUE && wbit && c == core) ? 1 : 0);
      check({nm, ".gparam"}, mon_gp[c] != 0, ok && op == OP_RD_DBG && c == core);
    end
    if (ok) begin
      case (op)
        OP_WR_DATA:   ref_mem[mkey(0, core, addr)] = wd;
        OP_WR_CODE:   ref_mem[mkey(1, core, addr)] = wd;
        OP_SET_RESET: ref_preset[core] = wd[0];
        OP_RD_DBG:    check({nm, ".dbgaddr"}, debug_reg_addr, addr[3:0]);
        default:      ;
      endcase
    end
    check({nm, ".preset"}, processor_reset, ref_preset);
  endtask

  logic [A-1:0] atab [4] = '{18'h00010, 18'h3FFFF, 18'h00000, 18'h15555};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ev;
    logic [2:0] exp_core [4];
    int bad_valid, bad_ready;
    int core;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_RD_DATA;
    bus.cmd_core  = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    wait_for_continue = '0;
    debug_data_out    = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    ref_preset = '1;

    @(negedge clock);
    check("rst.ready", bus.cmd_ready, 1);
    check("rst.valid", bus.rsp_valid, 0);
    check("rst.data", bus.rsp_data, 0);
    check("rst.err", bus.rsp_err, 0);
    check("rst.preset", processor_reset, 2'b11);
    check("rst.strobes", {data_wren, code_wren, debug_get_param, wait_continue_execution}, 0);
    check("rst.wev", wait_event, 0);
    @(posedge clock);
    #1;

    exec(OP_SET_RESET, 1, '0, '0);
    exec(OP_WR_DATA, 0, 18'h00010, 18'h2ABCD);
    exec(OP_RD_DATA, 0, 18'h00010, '0);
    exec(OP_CONTINUE, 1, '0, '0);
    wait_for_continue = 2'b10;
    exec(OP_CONTINUE, 1, '0, '0);
    debug_data_out = {18'h3FFFF, 18'h00123};
    exec(OP_RD_DBG, 0, 18'h5, '0);
    exec(OP_WR_DATA, 3, 18'h00010, 18'h11111);
    exec(OP_RD_CODE, 3, 18'h00010, '0);
    exec(OP_WR_CODE, 1, 18'h3FFFF, 18'h1F0F0);
    exec(OP_RD_CODE, 1, 18'h3FFFF, '0);
    exec(OP_RD_DATA, 1, 18'h00010, '0);
    exec(OP_STATUS, 0, '0, '0);

    // Reset while a read is in flight: no response may follow.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RD_DATA;
    bus.cmd_core  = 3'd0;
    bus.cmd_addr  = 18'h00010;
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    ref_preset = '1;
    bad_valid = 0;
    bad_ready = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      bad_valid += int'(bus.rsp_valid);
      bad_ready += int'(!bus.cmd_ready);
    end
    check("abort.rsp", bad_valid, 0);
    check("abort.ready", bad_ready, 0);
    check("abort.preset", processor_reset, ref_preset);
    @(posedge clock);
    #1;

    // Two cores enter their wait state in the same cycle.
    wait_for_continue = '0;
    repeat (3) @(posedge clock);
    #1 wait_for_continue = 2'b11;
`ifdef DEBUG_HUB_WAIT_EVENT_EN
    exp_ev   = 4'b0110;
    exp_core = '{3'd0, 3'd0, 3'd1, 3'd0};
`else
    exp_ev   = 4'b0000;
    exp_core = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("wev", wait_event, exp_ev[k]);
      check("wev.core", wait_event ? wait_event_core : 3'd0, exp_core[k]);
`ifndef DEBUG_HUB_WAIT_EVENT_EN
      check("wev.core_tied", wait_event_core, 3'd0);
`endif
    end
    @(posedge clock);
    #1;

    for (int n = 0; n < 250; n++) begin
      wait_for_continue = NC'($urandom);
      debug_data_out    = (NC*W)'({$urandom, $urandom});
      core = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NC, 7)) : int'($urandom_range(0, NC-1));
      exec(cmd_op_e'($urandom_range(0, 7)), core,
           atab[$urandom_range(0, 3)] ^ A'($urandom_range(0, 3)), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
